// File: rtl/requant_pkg.sv
// rtl/requant_pkg.sv - shared requantizer types, clamp bounds and conversion function
package requant_pkg;

  typedef enum logic [1:0] {
    SIGN1 = 2'd0,
    S2    = 2'd1,
    S4    = 2'd2,
    U4    = 2'd3
  } qmode_t;

  localparam int S2_MIN = -2;
  localparam int S2_MAX = 1;
  localparam int S4_MIN = -8;
  localparam int S4_MAX = 7;
  localparam int U4_MIN = 0;
  localparam int U4_MAX = 15;

  // Returns {sat, data[3:0]}; d is the sample already sign-extended to 32 bits.
  // Signed modes keep the low nibble of the clamped value, which is the
  // 4-bit sign extension of the narrower result.
  function automatic logic [4:0] requant(input logic signed [31:0] d, input qmode_t mode);
    int       lo;
    int       hi;
    logic [3:0] c;
    logic     sat;
    logic [4:0] r;
    lo = U4_MIN;
    hi = U4_MAX;
    case (mode)
      S2:      begin lo = S2_MIN; hi = S2_MAX; end
      S4:      begin lo = S4_MIN; hi = S4_MAX; end
      default: begin lo = U4_MIN; hi = U4_MAX; end
    endcase
    if (d < lo) begin
      c   = lo[3:0];
      sat = 1'b1;
    end else if (d > hi) begin
      c   = hi[3:0];
      sat = 1'b1;
    end else begin
      c   = d[3:0];
      sat = 1'b0;
    end
    r = {sat, c};
    if (mode == SIGN1) r = {1'b0, 3'b000, d[31]};
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot grant starting the search at prio
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  prio,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  winner
);

  logic [IDW-1:0] idx;
  logic           found;

  // Scan prio, prio+1, ... ; NREQ is a power of two so IDW-bit addition wraps mod NREQ.
  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = prio + IDW'(k);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    if (en && found) grant[winner] = 1'b1;
  end

endmodule

// File: rtl/requant_arbiter.sv
// rtl/requant_arbiter.sv - round-robin shared requantizer with output register and saturation counter
module requant_arbiter
  import requant_pkg::*;
#(
  parameter int IW   = 8,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NREQ*IW-1:0] req_data,
  input  logic [NREQ*2-1:0]  req_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic [IDW-1:0]   out_id,
  output logic             out_sat,
  input  logic             sat_clr,
  output logic [15:0]      sat_count
);

  logic [IDW-1:0] prio;
  logic [IDW-1:0] winner;
  logic           load;
  logic           xfer;
  logic [IW-1:0]  sel_data;
  logic [1:0]     sel_mode;
  logic signed [31:0] din;
  logic [4:0]     q;

  // The output slot can take a new sample when empty or draining this cycle.
  assign load = !out_valid || out_ready;
  assign xfer = |req_ready;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req    (req_valid),
    .prio   (prio),
    .en     (load && !rst),
    .grant  (req_ready),
    .winner (winner)
  );

  // Route the winning requester's sample and format into the shared requantizer.
  always_comb begin
    sel_data = '0;
    sel_mode = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IDW'(i)) begin
        sel_data = req_data[i*IW +: IW];
        sel_mode = req_mode[2*i +: 2];
      end
    end
    din = {{(32-IW){sel_data[IW-1]}}, sel_data};
    q   = requant(din, qmode_t'(sel_mode));
  end

  // Advance the round-robin pointer past the requester that just transferred.
  always_ff @(posedge clk) begin
    if (rst) prio <= '0;
    else if (xfer) prio <= winner + IDW'(1);
  end

  // Single-entry output register: load on transfer, otherwise empty on drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      out_sat   <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= q[3:0];
      out_id    <= winner;
      out_sat   <= q[4];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Count consumed clamped results, sticking at all-ones; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst || sat_clr) sat_count <= '0;
    else if (out_valid && out_ready && out_sat && sat_count != 16'hFFFF)
      sat_count <= sat_count + 16'd1;
  end

endmodule

// File: doc/requant_arbiter.md
# requant_arbiter

Shares one signed requantizer datapath (8-bit signed in, 1/2/4-bit signed-saturated or 4-bit unsigned-clamped out) among NREQ requesters. Round-robin grant, valid/ready on both sides, single-entry output register with 1-cycle latency. Sits between the feature-producing lanes and the packed low-precision writeback path, and counts saturation events for software monitoring.

## Interface
- IW, 8: input sample width, two's complement, IW ≥ 5
- NREQ, 4: number of requesters, power of two, 2..8
- IDW, $clog2(NREQ): requester-id width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester sample valid
- req_ready  out  NREQ  per-requester accept, one-hot or zero
- req_data  in  NREQ×IW  per-requester signed sample
- req_mode  in  NREQ×2  per-requester format: 0 SIGN1, 1 S2, 2 S4, 3 U4
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_data  out  4  result, right-justified and sign-extended (U4 zero-extended)
- out_id  out  IDW  index of the originating requester
- out_sat  out  1  result was clamped
- sat_clr  in  1  clear the saturation counter
- sat_count  out  16  saturating count of accepted results with out_sat=1

## Operation
- Arbitration: round-robin pointer `prio` (reset 0). Search order is prio, prio+1 … wrapping mod NREQ. The first requester with req_valid=1 wins.
- Grant is allowed when `load = !out_valid || out_ready`. req_ready[i]=1 only for the winner, only when load=1. It is combinational from req_valid/out_valid/out_ready/prio. A requester must not depend on req_ready to assert req_valid.
- Handshake: a transfer happens when req_valid[i] && req_ready[i]. On transfer, prio becomes winner+1 mod NREQ. With no transfer, prio holds.
- Format rules, with d = $signed(req_data):
  - SIGN1: out_data = {3'b0, d<0}; sat=0.
  - S2: clamp to [-2,1]; out_data = 4-bit sign-extension; sat = (d<-2 or d>1).
  - S4: clamp to [-8,7]; sat = (d<-8 or d>7).
  - U4: clamp to [0,15]; out_data unsigned; sat = (d<0 or d>15).
- Output register: on transfer, it captures out_data/out_id/out_sat and sets out_valid=1. Otherwise, if out_ready=1 it clears out_valid. While out_valid=1 and out_ready=0, all out_* hold stable.
- sat_count: increments by 1 when out_valid && out_ready && out_sat, and saturates at 16'hFFFF. sat_clr has priority over the increment (clear wins on the same cycle).

## Timing
- Reset values: out_valid=0, out_data=0, out_id=0, out_sat=0, sat_count=0, prio=0. req_ready=0 while rst=1.
- Latency: a sample accepted at edge N appears as out_valid=1 after edge N.
- Throughput: 1 result/cycle with out_ready held high. A back-to-back transfer is allowed in the same cycle the output drains.
- Backpressure: with out_valid=1 and out_ready=0, all req_ready=0. Nothing is dropped or overwritten.
- Simultaneous drain and new grant: the old result is consumed and the new one is loaded on the same edge, so out_valid stays 1.
- No requests: prio holds, and out_valid falls after drain.
- Reset mid-operation: the pending result is discarded, prio returns to 0, and the counter is cleared.
- A requester whose req_valid drops before grant loses its turn without penalty. prio is unchanged unless a transfer occurs.

## Structure
- Shared package `requant_pkg`:
  - enum `qmode_t` {SIGN1, S2, S4, U4}
  - clamp-bound constants per mode
  - function `requant(d, mode) -> {sat, data[3:0]}`
- Natural sub-module: `rr_arbiter` (NREQ request vector, prio, enable → one-hot grant, winner index), reused by other shared-resource controllers.
- The top level holds the datapath mux, the requant function call, the output register and the counter.

## Test plan
- Reset, then requester 0 sends d=-127 in S4 with out_ready=1. Required: next cycle out_data=4'h8, out_id=0, out_sat=1; sat_count=1 after the handshake.
- All 4 requesters held valid with out_ready=1 for 8 cycles. Required: out_id sequence 0,1,2,3,0,1,2,3, one result per cycle.
- Requester 2 sends d=5 in U4 with out_ready=0 for 3 cycles. Required: out_data=5, out_sat=0, req_ready all 0 throughout; a single output when out_ready rises.
- Sweep d from -128 to 127 on requester 1 in each mode. Required:
  - SIGN1 bit = 1 exactly for d<0.
  - S2 outputs span {-2..1}, with sat count 252.
  - U4 sat=1 for d<0 or d>15.
- Saturation counter preset near 16'hFFFF via a long saturating stream. Required: it holds at FFFF. sat_clr asserted together with a saturating handshake yields 0.
- rst asserted while out_valid=1 and prio=3. Required: next cycle out_valid=0. After release, requesters 0 and 3 both valid: grant goes to 0.
